// File: rtl/vco_quantizer.sv
// Multi-phase VCO quantizer: synchronises NPH ring-oscillator taps, counts edges over a
// DECIM-cycle window and offers one saturated count per window. Macro VCO_QUANTIZER_BOTH_EDGES_EN.
module vco_quantizer #(
  parameter int NPH   = 4,
  parameter int DECIM = 64,
  parameter int OUT_W = 16,
  parameter int CNT_W = $clog2(DECIM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic [NPH-1:0]   phase,
  output logic [OUT_W-1:0] sample_data,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overflow,
  input  logic             overflow_clr,
  output logic             busy
);

  localparam int INC_W = $clog2(NPH + 1);
  localparam int SUM_W = (OUT_W + 2 > INC_W + 1) ? OUT_W + 2 : INC_W + 1;
  localparam logic [SUM_W-1:0] MAX_VAL = {{(SUM_W - OUT_W){1'b0}}, {OUT_W{1'b1}}};
  localparam logic [OUT_W:0]   ACC_SAT = {1'b1, {OUT_W{1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [NPH-1:0]   s1, s2, s3;
  logic [NPH-1:0]   edges;
  logic [INC_W-1:0] inc;
  logic [OUT_W:0]   acc;
  logic [CNT_W-1:0] win_cnt;
  logic [SUM_W-1:0] sum;
  logic             sat;
  logic [OUT_W-1:0] final_val;
  logic [OUT_W:0]   acc_next;
  logic             last;
  logic             close;
  logic             load;
  logic             drop;

`ifdef VCO_QUANTIZER_BOTH_EDGES_EN
  always_comb edges = s2 ^ s3;
`else
  always_comb edges = s2 & ~s3;
`endif

  always_comb begin
    inc = '0;
    for (int i = 0; i < NPH; i++) begin
      inc = inc + INC_W'(edges[i]);
    end
  end

  // acc parks at 2^OUT_W once saturated, so it can never wrap back to a small value.
  always_comb begin
    sum       = SUM_W'(acc) + SUM_W'(inc);
    sat       = sum > MAX_VAL;
    final_val = sat ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
    acc_next  = sat ? ACC_SAT : sum[OUT_W:0];
    last      = win_cnt == CNT_W'(DECIM - 1);
    close     = (state == RUN) && !enb && last;
    load      = close && (!sample_valid || sample_ready);
    drop      = close && sample_valid && !sample_ready;
  end

  // Handshake: a sample transfers on any edge where sample_valid && sample_ready; sample_valid
  // stays high and sample_data stays stable until that transfer, whatever enb does.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      s1           <= '0;
      s2           <= '0;
      s3           <= '0;
      acc          <= '0;
      win_cnt      <= '0;
      busy         <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      s1 <= phase;
      s2 <= s1;
      s3 <= s2;

      case (state)
        IDLE: begin
          acc     <= '0;
          win_cnt <= '0;
          if (!enb) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (enb) begin
            state   <= IDLE;
            busy    <= 1'b0;
            acc     <= '0;
            win_cnt <= '0;
          end else if (last) begin
            acc     <= '0;
            win_cnt <= '0;
          end else begin
            acc     <= acc_next;
            win_cnt <= win_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (load) begin
        sample_data  <= final_val;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end

      // A fresh drop outranks a clear arriving in the same cycle.
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vco_quantizer.sv
// Directed bench for vco_quantizer: a table of windowed handshake vectors plus hand-written
// sequences for reset, enable abort and saturation.
module tb_vco_quantizer;

`ifdef VCO_QUANTIZER_BOTH_EDGES_EN
  localparam int EPW = 16;
`else
  localparam int EPW = 8;
`endif

  logic       clk;
  logic       rst;
  logic       enb;
  logic [3:0] phase;
  logic [7:0] sample_data;
  logic       sample_valid;
  logic       sample_ready;
  logic       overflow;
  logic       overflow_clr;
  logic       busy;

  logic       enb_s;
  logic [3:0] s_data;
  logic       s_valid;
  logic       ready_s;
  logic       s_ovf;
  logic       clr_s;
  logic       s_busy;

  int n_chk;
  int n_pass;
  int mode;
  int tick;
  int n;

  typedef struct {
    int         steps;
    logic       ready;
    logic       clr;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ovf;
    logic       exp_busy;
  } vec_t;

  vec_t tbl[13];

  vco_quantizer #(.NPH(4), .DECIM(8), .OUT_W(8)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .enb          (enb),
    .phase        (phase),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .busy         (busy)
  );

  vco_quantizer #(.NPH(4), .DECIM(8), .OUT_W(4)) u_sat (
    .clk          (clk),
    .rst          (rst),
    .enb          (enb_s),
    .phase        (phase),
    .sample_data  (s_data),
    .sample_valid (s_valid),
    .sample_ready (ready_s),
    .overflow     (s_ovf),
    .overflow_clr (clr_s),
    .busy         (s_busy)
  );

  // Clock and reset-independent watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Phase source: mode 0 holds, 1 = period-4 square waves offset by a quarter, 2 = toggle each clk.
  initial begin
    tick  = 0;
    phase = 4'b0000;
    forever begin
      @(negedge clk);
      tick++;
      case (mode)
        1: for (int i = 0; i < 4; i++) phase[i] = ((tick + i) % 4) < 2;
        2: phase = {4{tick[0]}};
        default: phase = phase;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Steps until the selected instance shows sample_valid; returns -1 if it never does.
  task automatic wait_valid(input bit use_sat, output int cycles);
    cycles = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if ((use_sat ? s_valid : sample_valid) === 1'b1) begin
        cycles = k;
        break;
      end
    end
  endtask

  initial begin
    n_chk        = 0;
    n_pass       = 0;
    mode         = 1;
    rst          = 1'b1;
    enb          = 1'b1;
    sample_ready = 1'b0;
    overflow_clr = 1'b0;
    enb_s        = 1'b1;
    ready_s      = 1'b1;
    clr_s        = 1'b0;

    //            steps rdy clr  valid data ovf busy
    tbl[0]  = '{8, 1'b1, 1'b0, 1'b0, 8'd0,       1'b0, 1'b1};
    tbl[1]  = '{1, 1'b1, 1'b0, 1'b1, 8'(EPW),    1'b0, 1'b1};
    tbl[2]  = '{1, 1'b1, 1'b0, 1'b0, 8'(EPW),    1'b0, 1'b1};
    tbl[3]  = '{7, 1'b0, 1'b0, 1'b1, 8'(EPW),    1'b0, 1'b1};
    tbl[4]  = '{8, 1'b0, 1'b0, 1'b1, 8'(EPW),    1'b1, 1'b1};
    tbl[5]  = '{1, 1'b0, 1'b1, 1'b1, 8'(EPW),    1'b0, 1'b1};
    tbl[6]  = '{1, 1'b1, 1'b0, 1'b0, 8'(EPW),    1'b0, 1'b1};
    tbl[7]  = '{6, 1'b0, 1'b0, 1'b1, 8'(EPW),    1'b0, 1'b1};
    tbl[8]  = '{7, 1'b0, 1'b0, 1'b1, 8'(EPW),    1'b0, 1'b1};
    tbl[9]  = '{1, 1'b1, 1'b0, 1'b1, 8'(EPW),    1'b0, 1'b1};
    tbl[10] = '{1, 1'b0, 1'b0, 1'b1, 8'(EPW),    1'b0, 1'b1};
    tbl[11] = '{7, 1'b0, 1'b1, 1'b1, 8'(EPW),    1'b1, 1'b1};
    tbl[12] = '{1, 1'b0, 1'b0, 1'b1, 8'(EPW),    1'b1, 1'b1};

    repeat (3) step();
    chk("rst_data",  sample_data,  0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_ovf",   overflow,     0);
    chk("rst_busy",  busy,         0);
    rst = 1'b0;
    repeat (6) step();
    chk("idle_busy", busy, 0);

    // Steady square-wave windows with ready high, then backpressure and overflow handling.
    enb = 1'b0;
    for (int i = 0; i < 13; i++) begin
      sample_ready = tbl[i].ready;
      overflow_clr = tbl[i].clr;
      repeat (tbl[i].steps) step();
      chk($sformatf("row%0d_valid", i), sample_valid, tbl[i].exp_valid);
      chk($sformatf("row%0d_data", i),  sample_data,  tbl[i].exp_data);
      chk($sformatf("row%0d_ovf", i),   overflow,     tbl[i].exp_ovf);
      chk($sformatf("row%0d_busy", i),  busy,         tbl[i].exp_busy);
    end
    overflow_clr = 1'b0;

    // Reset at win_cnt=3 with a sample pending and overflow set.
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("midrst_valid", sample_valid, 0);
    chk("midrst_data",  sample_data,  0);
    chk("midrst_ovf",   overflow,     0);
    chk("midrst_busy",  busy,         0);
    rst          = 1'b0;
    sample_ready = 1'b1;
    wait_valid(1'b0, n);
    chk("midrst_latency", n, 9);

    // Abort at win_cnt=5 with static phases; next window starts from scratch.
    mode = 0;
    repeat (5) step();
    chk("abort_busy_pre", busy, 1);
    enb = 1'b1;
    step();
    chk("abort_busy", busy, 0);
    chk("abort_valid", sample_valid, 0);
    step();
    enb          = 1'b0;
    sample_ready = 1'b0;
    wait_valid(1'b0, n);
    chk("abort_latency", n, 9);
    chk("abort_data", sample_data, 0);

    // Saturation on the 4-bit instance: 16 counts clip to 15.
    mode = 2;
    repeat (4) step();
    enb_s = 1'b0;
    wait_valid(1'b1, n);
    chk("sat_latency", n, 9);
    chk("sat_data0", s_data, 15);
    step();
    chk("sat_valid_drop", s_valid, 0);
    wait_valid(1'b1, n);
    chk("sat_period", n, 7);
    chk("sat_data1", s_data, 15);
    chk("sat_ovf", s_ovf, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
